// File: rtl/siaminer_pkg.sv
// Shared constants for the miner's host link: frame header/command/length bytes
// and the response framer state encoding.
package siaminer_pkg;

    localparam logic [7:0] HDR_CMD   = 8'hAA;
    localparam logic [7:0] HDR_RESP  = 8'h55;
    localparam logic [7:0] CMD_WORK  = 8'h00;
    localparam logic [7:0] CMD_LOOP  = 8'h01;
    localparam logic [7:0] LEN_NONCE = 8'h04;
    localparam logic [7:0] LEN_LOOP  = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_CMD,
        ST_LEN,
        ST_DATA
    } frame_state_e;

    // Little-endian byte select from a 32-bit payload word.
    function automatic logic [7:0] payload_byte(input logic [31:0] data, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = data[7:0];
            2'd1:    b = data[15:8];
            2'd2:    b = data[23:16];
            default: b = data[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/resp_framer.sv
// Response framer: buffers one found-nonce and one loop-echo request and
// serialises them as 0x55/cmd/len/payload frames toward the UART transmitter.
module resp_framer
    import siaminer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        nonce_valid,
    input  logic [31:0] nonce,
    output logic        nonce_ready,
    input  logic        loop_valid,
    input  logic [7:0]  loop_byte,
    output logic        loop_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        frame_done
);

    frame_state_e state_q, state_d;
    logic         nonce_full_q, nonce_full_d;
    logic [31:0]  nonce_data_q, nonce_data_d;
    logic         loop_full_q, loop_full_d;
    logic [7:0]   loop_data_q, loop_data_d;
    logic         sel_loop_q, sel_loop_d;
    logic [31:0]  frame_data_q, frame_data_d;
    logic [1:0]   idx_q, idx_d;

    logic [7:0]   frame_cmd;
    logic [7:0]   frame_len;
    logic [1:0]   last_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            nonce_full_q <= 1'b0;
            nonce_data_q <= '0;
            loop_full_q  <= 1'b0;
            loop_data_q  <= '0;
            sel_loop_q   <= 1'b0;
            frame_data_q <= '0;
            idx_q        <= '0;
        end else begin
            state_q      <= state_d;
            nonce_full_q <= nonce_full_d;
            nonce_data_q <= nonce_data_d;
            loop_full_q  <= loop_full_d;
            loop_data_q  <= loop_data_d;
            sel_loop_q   <= sel_loop_d;
            frame_data_q <= frame_data_d;
            idx_q        <= idx_d;
        end
    end

    assign frame_cmd   = sel_loop_q ? CMD_LOOP : CMD_WORK;
    assign frame_len   = sel_loop_q ? LEN_LOOP : LEN_NONCE;
    assign last_idx    = frame_len[1:0] - 2'd1;
    assign nonce_ready = ~nonce_full_q;
    assign loop_ready  = ~loop_full_q;
    assign busy        = (state_q != ST_IDLE);

    always_comb begin
        state_d      = state_q;
        nonce_full_d = nonce_full_q;
        nonce_data_d = nonce_data_q;
        loop_full_d  = loop_full_q;
        loop_data_d  = loop_data_q;
        sel_loop_d   = sel_loop_q;
        frame_data_d = frame_data_q;
        idx_d        = idx_q;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        frame_done   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The payload is copied out of the holding register here, because
                // that register is released (and may refill) once the header goes.
                if (nonce_full_q) begin
                    sel_loop_d   = 1'b0;
                    frame_data_d = nonce_data_q;
                    state_d      = ST_HDR;
                end else if (loop_full_q) begin
                    sel_loop_d   = 1'b1;
                    frame_data_d = {24'h000000, loop_data_q};
                    state_d      = ST_HDR;
                end
            end
            ST_HDR: begin
                tx_valid = 1'b1;
                tx_data  = HDR_RESP;
                if (tx_ready) begin
                    state_d = ST_CMD;
                    if (sel_loop_q) loop_full_d  = 1'b0;
                    else            nonce_full_d = 1'b0;
                end
            end
            ST_CMD: begin
                tx_valid = 1'b1;
                tx_data  = frame_cmd;
                if (tx_ready) state_d = ST_LEN;
            end
            ST_LEN: begin
                tx_valid = 1'b1;
                tx_data  = frame_len;
                if (tx_ready) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                tx_valid = 1'b1;
                tx_data  = payload_byte(frame_data_q, idx_q);
                if (tx_ready) begin
                    if (idx_q == last_idx) begin
                        frame_done = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (nonce_valid && !nonce_full_q) begin
            nonce_full_d = 1'b1;
            nonce_data_d = nonce;
        end
        if (loop_valid && !loop_full_q) begin
            loop_full_d = 1'b1;
            loop_data_d = loop_byte;
        end
    end

endmodule

// File: tb/tb_resp_framer.sv
// Directed bench for resp_framer: records every transferred byte and compares
// against hand-built frame sequences.
module tb_resp_framer;

    logic        clk;
    logic        rst;
    logic        nonce_valid;
    logic [31:0] nonce;
    logic        nonce_ready;
    logic        loop_valid;
    logic [7:0]  loop_byte;
    logic        loop_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        frame_done;

    resp_framer dut (
        .clk         (clk),
        .rst         (rst),
        .nonce_valid (nonce_valid),
        .nonce       (nonce),
        .nonce_ready (nonce_ready),
        .loop_valid  (loop_valid),
        .loop_byte   (loop_byte),
        .loop_ready  (loop_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [7:0]  got_bytes[$];
    logic        got_done[$];
    int unsigned got_cyc[$];
    logic [7:0]  exp_bytes[$];
    logic        exp_done[$];

    int unsigned cyc = 0;
    int unsigned spurious_done = 0;
    int unsigned stall_err = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Transfers are observed mid-cycle, just before the edge that commits them.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (tx_valid && tx_ready) begin
                got_bytes.push_back(tx_data);
                got_done.push_back(frame_done);
                got_cyc.push_back(cyc);
            end else if (frame_done) begin
                spurious_done++;
            end
            if (prev_stall && (!tx_valid || tx_data != prev_data)) stall_err++;
        end
        prev_stall = !rst && tx_valid && !tx_ready;
        prev_data  = tx_data;
    end

    task automatic add_frame(input logic [7:0] cmd, input logic [7:0] len, input logic [31:0] data);
        logic [31:0] d;
        d = data;
        exp_bytes.push_back(8'h55); exp_done.push_back(1'b0);
        exp_bytes.push_back(cmd);   exp_done.push_back(1'b0);
        exp_bytes.push_back(len);   exp_done.push_back(1'b0);
        for (int unsigned i = 0; i < len; i++) begin
            exp_bytes.push_back(d[8*i +: 8]);
            exp_done.push_back(i == len - 1);
        end
    endtask

    task automatic compare_stream(input string tag);
        int unsigned n;
        check_eq({tag, "_count"}, got_bytes.size(), exp_bytes.size());
        n = (got_bytes.size() < exp_bytes.size()) ? got_bytes.size() : exp_bytes.size();
        for (int unsigned i = 0; i < n; i++) begin
            check_eq($sformatf("%s_byte%0d", tag, i), got_bytes[i], exp_bytes[i]);
            check_eq($sformatf("%s_done%0d", tag, i), got_done[i], exp_done[i]);
        end
    endtask

    task automatic clear_streams();
        got_bytes.delete(); got_done.delete(); got_cyc.delete();
        exp_bytes.delete(); exp_done.delete();
    endtask

    // Drives a one-cycle request; returns just after the capturing edge.
    task automatic pulse(input logic nv, input logic [31:0] n, input logic lv, input logic [7:0] l);
        @(posedge clk); #1;
        nonce_valid = nv; loop_valid = lv;
        if (nv) nonce = n;
        if (lv) loop_byte = l;
        @(posedge clk); #1;
        nonce_valid = 1'b0; loop_valid = 1'b0;
    endtask

    task automatic wait_quiet(input bit rnd, input int unsigned budget);
        int unsigned quiet = 0;
        int unsigned n = 0;
        while (quiet < 3 && n < budget) begin
            @(posedge clk); #1;
            if (rnd) tx_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (!busy && nonce_ready && loop_ready) quiet++;
            else quiet = 0;
            n++;
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        check_eq("quiet_reached", 32'(quiet >= 3), 32'd1);
    endtask

    initial begin
        rst = 1'b1; nonce_valid = 1'b0; nonce = '0;
        loop_valid = 1'b0; loop_byte = '0; tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_nonce_ready", nonce_ready, 1);
        check_eq("rst_loop_ready", loop_ready, 1);
        check_eq("rst_tx_valid", tx_valid, 0);
        check_eq("rst_tx_data", tx_data, 8'h00);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_frame_done", frame_done, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Single nonce frame, latency, and isolation from live input changes.
        clear_streams();
        pulse(1'b1, 32'h12345678, 1'b0, 8'h00);
        nonce = 32'hFFFFFFFF;
        @(negedge clk);
        check_eq("lat_n1_nonce_ready", nonce_ready, 0);
        check_eq("lat_n1_tx_valid", tx_valid, 0);
        @(negedge clk);
        check_eq("lat_n2_tx_valid", tx_valid, 1);
        check_eq("lat_n2_tx_data", tx_data, 8'h55);
        check_eq("lat_n2_busy", busy, 1);
        wait_quiet(1'b0, 200);
        add_frame(8'h00, 8'h04, 32'h12345678);
        compare_stream("nonce1");

        // Loop frame; holding register released once the header transfers.
        clear_streams();
        pulse(1'b0, 32'h0, 1'b1, 8'hA5);
        loop_byte = 8'h00;
        @(negedge clk);
        check_eq("loop_n1_ready", loop_ready, 0);
        @(negedge clk);
        check_eq("loop_n2_ready", loop_ready, 0);
        check_eq("loop_n2_tx_data", tx_data, 8'h55);
        @(negedge clk);
        check_eq("loop_n3_ready", loop_ready, 1);
        check_eq("loop_n3_tx_data", tx_data, 8'h01);
        wait_quiet(1'b0, 200);
        add_frame(8'h01, 8'h01, 32'h000000A5);
        compare_stream("loop1");

        // Simultaneous requests: nonce wins, loop follows.
        clear_streams();
        pulse(1'b1, 32'hDEADBEEF, 1'b1, 8'h3C);
        wait_quiet(1'b0, 200);
        add_frame(8'h00, 8'h04, 32'hDEADBEEF);
        add_frame(8'h01, 8'h01, 32'h0000003C);
        compare_stream("both");

        // Backpressure with random tx_ready.
        clear_streams();
        pulse(1'b1, 32'h00000001, 1'b0, 8'h00);
        wait_quiet(1'b1, 400);
        add_frame(8'h00, 8'h04, 32'h00000001);
        compare_stream("stall");

        // Second nonce queued during a frame; third ignored while register full.
        clear_streams();
        pulse(1'b1, 32'h01020304, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        pulse(1'b1, 32'hCAFEF00D, 1'b0, 8'h00);
        @(posedge clk); #1;
        check_eq("third_nonce_ready", nonce_ready, 0);
        nonce = 32'h99999999; nonce_valid = 1'b1;
        @(posedge clk); #1 nonce_valid = 1'b0;
        wait_quiet(1'b0, 200);
        add_frame(8'h00, 8'h04, 32'h01020304);
        add_frame(8'h00, 8'h04, 32'hCAFEF00D);
        compare_stream("b2b");
        if (got_cyc.size() >= 8) check_eq("b2b_gap", got_cyc[7] - got_cyc[6], 2);
        else check_eq("b2b_gap_missing", got_cyc.size(), 8);

        // Reset mid-frame once LEN has transferred; pending loop request dropped.
        clear_streams();
        pulse(1'b1, 32'h12345678, 1'b1, 8'h77);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1; tx_ready = 1'b0;
        @(posedge clk); #1 rst = 1'b0; tx_ready = 1'b1;
        @(negedge clk);
        check_eq("abort_tx_valid", tx_valid, 0);
        check_eq("abort_nonce_ready", nonce_ready, 1);
        check_eq("abort_loop_ready", loop_ready, 1);
        check_eq("abort_busy", busy, 0);
        repeat (10) @(negedge clk);
        exp_bytes = '{8'h55, 8'h00, 8'h04};
        exp_done  = '{1'b0, 1'b0, 1'b0};
        compare_stream("abort");

        check_eq("spurious_frame_done", spurious_done, 0);
        check_eq("stall_data_unstable", stall_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/resp_framer.md
RESP_FRAMER -- requirements
Module: resp_framer

Interface
REQ-001 Parameters: none; all frame constants come from the shared package.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 nonce_valid  in  1  found-nonce request from core; sampled only when nonce_ready=1.
REQ-005 nonce  in  32  found nonce value.
REQ-006 nonce_ready  out  1  nonce holding register empty.
REQ-007 loop_valid  in  1  loop-test echo request from command parser; sampled only when loop_ready=1.
REQ-008 loop_byte  in  8  byte to echo.
REQ-009 loop_ready  out  1  loop holding register empty.
REQ-010 tx_data  out  8  byte to UART transmitter.
REQ-011 tx_valid  out  1  tx_data valid; byte transfers on cycle with tx_valid=1 and tx_ready=1.
REQ-012 tx_ready  in  1  UART transmitter can accept a byte.
REQ-013 busy  out  1  frame in progress (state not IDLE).
REQ-014 frame_done  out  1  one-cycle pulse on the cycle the last byte of a frame transfers.

Function
REQ-015 Frame format: 0x55 header, cmd byte, len byte, then len payload bytes.
REQ-016 Nonce frame: cmd 0x00, len 0x04, payload nonce[7:0], [15:8], [23:16], [31:24] in that order.
REQ-017 Loop frame: cmd 0x01, len 0x01, payload loop_byte as captured.
REQ-018 Holding registers: one per source; nonce_valid & nonce_ready captures nonce and clears nonce_ready next cycle; same for loop; a register is freed on the cycle its frame's first byte (header) transfers.
REQ-019 Requests arriving while a frame is in progress are captured if their register is empty and sent after the current frame completes.
REQ-020 FSM states: IDLE, HDR, CMD, LEN, DATA; IDLE->HDR when any register full; HDR->CMD->LEN->DATA each on byte transfer; DATA->IDLE on transfer of last payload byte.
REQ-021 Arbitration in IDLE: nonce register has priority over loop register when both full; selection frozen for the whole frame.
REQ-022 Payload byte index counter 2 bits; reset to 0 on entering DATA; increments per transfer; last byte when index == len-1.
REQ-023 tx_valid=1 in HDR, CMD, LEN, DATA; 0 in IDLE; tx_data stable while tx_valid=1 and tx_ready=0.
REQ-024 Latency: request captured in cycle N with FSM IDLE -> tx_valid=1 with 0x55 in cycle N+2 (N+1 register, N+2 HDR).
REQ-025 tx_ready held 0: FSM stalls indefinitely, no byte lost or duplicated.
REQ-026 Back-to-back: after frame_done, next pending frame's header presented no earlier than the second following cycle (via IDLE).
REQ-027 Frame payload bytes come from the holding-register copy, not live inputs; input changes after capture have no effect.

Reset
REQ-028 On rst: FSM IDLE, both holding registers empty, nonce_ready=1, loop_ready=1, tx_valid=0, tx_data=0x00, busy=0, frame_done=0, index=0.
REQ-029 rst asserted mid-frame aborts the frame immediately; no remaining bytes emitted; captured requests discarded.

Structure
REQ-030 Shared package siaminer_pkg holds HDR_CMD=0xAA, HDR_RESP=0x55, CMD_WORK=0x00, CMD_LOOP=0x01, LEN_NONCE=0x04, LEN_LOOP=0x01 and the FSM state enumeration.
REQ-031 Single module, no sub-modules; holding registers and FSM in one file.

Verification
REQ-032 nonce=0x12345678 pulse, tx_ready=1 -> bytes 55 00 04 78 56 34 12, frame_done on 0x12 transfer.
REQ-033 loop_byte=0xA5 pulse -> bytes 55 01 01 A5; loop_ready returns 1 after 0x55 transfers.
REQ-034 nonce=0xDEADBEEF and loop_byte=0x3C same cycle -> 55 00 04 EF BE AD DE then 55 01 01 3C.
REQ-035 tx_ready toggled randomly 0/1 during nonce 0x00000001 frame -> exact sequence 55 00 04 01 00 00 00, no duplicates.
REQ-036 rst asserted after LEN byte of nonce frame -> tx_valid=0 next cycle, no payload bytes, ready signals=1.
REQ-037 Second nonce 0xCAFEF00D pulsed during first frame -> captured, sent as complete frame immediately after first; third pulse while nonce_ready=0 ignored.
